cpu_control_unit_v3: RTL and testbench
======================================

Name: cpu_control_unit_v3

Overview:
Pipelined RV32I control unit, successor to the single-decode v2 control unit. Decodes opcode/funct fields in the Decode stage and carries the control word through E, M and W stage registers with stall and flush support. Resolves branches and jumps in E from the ALU flags. Adds U-type, JALR, full RV32I ALU op set, load/store size and illegal-opcode detection. Sits between the instruction decode logic, the hazard unit and the datapath stage muxes.

Parameters:
ALU_SEL_W, 4, width of the ALU operation select; must be >= 4.
IMD_SRC_W, 3, width of the immediate-format select; must be >= 3.
RES_SRC_W, 2, width of the writeback result select.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
opc  in  7  instruction opcode, D stage
funct3  in  3  instruction funct3, D stage
funct7  in  1  instruction bit 30 (funct7[5]), D stage
stall_e  in  1  hold the E-stage register
flush_e  in  1  replace the E-stage contents with a bubble
alu_zero_e  in  1  ALU result == 0, E stage
alu_lt_e  in  1  signed less-than flag, E stage
alu_ltu_e  in  1  unsigned less-than flag, E stage
imd_src_d  out  IMD_SRC_W  immediate format, combinational from D
illegal_d  out  1  unsupported opcode, combinational from D
alu_op_sel_e  out  ALU_SEL_W  ALU operation
alu_a_src_e  out  1  ALU A select: 0 = rs1, 1 = PC (AUIPC)
alu_b_src_e  out  1  ALU B select: 0 = rs2, 1 = immediate
pc_src_e  out  1  redirect fetch (branch taken or jump)
pc_tgt_src_e  out  1  target select: 0 = PC+imm, 1 = ALU result (JALR)
mem_wr_en_m  out  1  store enable
mem_size_m  out  3  funct3 of the load/store
regfl_wr_en_m  out  1  register-file write enable, M copy (for forwarding)
result_src_m  out  RES_SRC_W  result select, M copy
regfl_wr_en_w  out  1  register-file write enable, W
result_src_w  out  RES_SRC_W  result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate

Behaviour:
- Decode (combinational): opcodes LOAD, S_TYPE, R_TYPE, I_TYPE, B_TYPE, J_TYPE, JALR, LUI, AUIPC.
- imd_src: I-format = 000 (LOAD, I_TYPE, JALR); S = 001; B = 010; J = 011; U = 100 (LUI, AUIPC).
- Any other opcode: illegal_d = 1 and the control word is all-zero (bubble).
- Result select: LUI = 11; JAL/JALR = 10; LOAD = 01; all others = 00.
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
- R_TYPE/I_TYPE ops by funct3:
  - 000: SUB only when R_TYPE and funct7 = 1, otherwise ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if funct7 = 1, else SRL (both types).
  - 110: OR. 111: AND.
- LOAD, S_TYPE, JALR and AUIPC use ADD. B_TYPE uses SUB. JAL and LUI use ADD (don't care).
- E register holds: jmp, bra, jalr, funct3, alu_op_sel, alu_a_src, alu_b_src, mem_wr_en, regfl_wr_en, result_src.
- E register update priority: rst > flush_e > stall_e > load.
  - rst or flush_e: load bubble, i.e. every enable 0 and every select 0.
  - stall_e (without flush_e): hold the current contents.
- M register: loads a bubble when rst or stall_e; otherwise captures the E contents.
- W register: loads a bubble on rst; otherwise captures the M contents every cycle.
- Reset: every registered output is 0 one cycle after rst is sampled high, including mid-stream. Combinational D outputs keep following their inputs.
- pc_src_e = jmp_e | (bra_e & cond), combinational in E. cond by funct3_e:
  - 000 BEQ = zero; 001 BNE = !zero.
  - 100 BLT = lt; 101 BGE = !lt.
  - 110 BLTU = ltu; 111 BGEU = !ltu.
  - 010 and 011 give cond = 0.
- pc_tgt_src_e = jalr_e.
- When stall_e is high, pc_src_e still reflects the held instruction. The hazard unit gates it.
- Latency: D to E outputs 1 cycle, to M 2 cycles, to W 3 cycles.

Decomposition:
- pkg_cpu_typedefs gains: opcode constants JALR, LUI, AUIPC; enum alu_sel_t (10 codes); imd_src_t; res_src_t; packed struct ctrl_word_t for the stage registers; BUBBLE constant.
- One sub-module, cpu_ctrl_decoder: the combinational decoder from opc/funct3/funct7 to ctrl_word_t, imd_src and illegal.
- The top module keeps the three stage registers and the branch-condition logic.

Test Plan:
- R-type SUB (opc 0110011, funct3 000, funct7 1), no stalls -> cycle +1: alu_op_sel_e = 1, alu_b_src_e = 0; cycle +2: regfl_wr_en_m = 1; cycle +3: regfl_wr_en_w = 1, result_src_w = 00.
- I-type SRAI (0010011, 101, funct7 1) -> alu_op_sel_e = 9, alu_b_src_e = 1. ADDI with funct7 = 1 -> alu_op_sel_e = 0 (not SUB).
- BLTU (1100011, 110) with alu_ltu_e = 1 -> pc_src_e = 1, pc_tgt_src_e = 0. Same instruction with alu_ltu_e = 0 -> pc_src_e = 0. mem/regfile enables stay 0 in M and W.
- JALR (1100111) -> imd_src_d = 000; pc_src_e = 1, pc_tgt_src_e = 1; result_src_w = 10, regfl_wr_en_w = 1. LUI (0110111) -> imd_src_d = 100, result_src_w = 11.
- Store SW in E, stall_e high 2 cycles -> E held; M carries bubbles (mem_wr_en_m = 0); on release, mem_wr_en_m = 1 and mem_size_m = 010 exactly once. flush_e together with stall_e -> E becomes a bubble.
- Opcode 1111111 -> illegal_d = 1 and no enables propagate. Assert rst with valid ops in E/M/W -> all registered outputs 0 the next cycle.

Source files
------------

// File: rtl/cpu_control_unit_v3_pkg.sv
// Shared RV32I control types: opcodes, ALU/immediate/result selects.
// Also the packed control word carried through the E/M/W registers.
package pkg_cpu_typedefs;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_J     = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_sel_t;

  typedef enum logic [2:0] {
    IMD_I = 3'b000,
    IMD_S = 3'b001,
    IMD_B = 3'b010,
    IMD_J = 3'b011,
    IMD_U = 3'b100
  } imd_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_t;

  typedef struct packed {
    logic       jmp;
    logic       bra;
    logic       jalr;
    logic [2:0] funct3;
    alu_sel_t   alu_op_sel;
    logic       alu_a_src;
    logic       alu_b_src;
    logic       mem_wr_en;
    logic       regfl_wr_en;
    res_src_t   result_src;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE = ctrl_word_t'('0);

endpackage

// File: rtl/cpu_control_unit_v3_decoder.sv
// Combinational D-stage decoder: opc/funct3/funct7 -> control word.
// Ports: opc, funct3, funct7 in; cw, imd_src, illegal out.
module cpu_ctrl_decoder
  import pkg_cpu_typedefs::*;
(
  input  logic [6:0]  opc,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  output ctrl_word_t  cw,
  output imd_src_t    imd_src,
  output logic        illegal
);

  alu_sel_t w_arith;
  logic     w_is_r;

  assign w_is_r = (opc == OPC_R);

  // Shared R/I op table; SUB exists only for register-register.
  always_comb begin
    w_arith = ALU_ADD;
    case (funct3)
      3'b000:  w_arith = (w_is_r && funct7) ? ALU_SUB : ALU_ADD;
      3'b001:  w_arith = ALU_SLL;
      3'b010:  w_arith = ALU_SLT;
      3'b011:  w_arith = ALU_SLTU;
      3'b100:  w_arith = ALU_XOR;
      3'b101:  w_arith = funct7 ? ALU_SRA : ALU_SRL;
      3'b110:  w_arith = ALU_OR;
      default: w_arith = ALU_AND;
    endcase
  end

  always_comb begin
    cw        = BUBBLE;
    imd_src   = IMD_I;
    illegal   = 1'b0;
    cw.funct3 = funct3;
    case (opc)
      OPC_LOAD: begin
        cw.alu_b_src   = 1'b1;
        cw.regfl_wr_en = 1'b1;
        cw.result_src  = RES_MEM;
      end
      OPC_S: begin
        imd_src       = IMD_S;
        cw.alu_b_src  = 1'b1;
        cw.mem_wr_en  = 1'b1;
      end
      OPC_R: begin
        cw.alu_op_sel  = w_arith;
        cw.regfl_wr_en = 1'b1;
      end
      OPC_I: begin
        cw.alu_op_sel  = w_arith;
        cw.alu_b_src   = 1'b1;
        cw.regfl_wr_en = 1'b1;
      end
      OPC_B: begin
        imd_src       = IMD_B;
        cw.bra        = 1'b1;
        cw.alu_op_sel = ALU_SUB;
      end
      OPC_J: begin
        imd_src        = IMD_J;
        cw.jmp         = 1'b1;
        cw.regfl_wr_en = 1'b1;
        cw.result_src  = RES_PC4;
      end
      OPC_JALR: begin
        cw.jmp         = 1'b1;
        cw.jalr        = 1'b1;
        cw.alu_b_src   = 1'b1;
        cw.regfl_wr_en = 1'b1;
        cw.result_src  = RES_PC4;
      end
      OPC_LUI: begin
        imd_src        = IMD_U;
        cw.alu_b_src   = 1'b1;
        cw.regfl_wr_en = 1'b1;
        cw.result_src  = RES_IMM;
      end
      OPC_AUIPC: begin
        imd_src        = IMD_U;
        cw.alu_a_src   = 1'b1;
        cw.alu_b_src   = 1'b1;
        cw.regfl_wr_en = 1'b1;
      end
      default: begin
        cw      = BUBBLE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_unit_v3.sv
// Pipelined RV32I control: decode in D, E/M/W control registers,
// branch resolution in E. Ports: D fields, stall/flush, ALU flags in.
module cpu_control_unit_v3
  import pkg_cpu_typedefs::*;
#(
  parameter int ALU_SEL_W = 4,
  parameter int IMD_SRC_W = 3,
  parameter int RES_SRC_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opc,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 stall_e,
  input  logic                 flush_e,
  input  logic                 alu_zero_e,
  input  logic                 alu_lt_e,
  input  logic                 alu_ltu_e,
  output logic [IMD_SRC_W-1:0] imd_src_d,
  output logic                 illegal_d,
  output logic [ALU_SEL_W-1:0] alu_op_sel_e,
  output logic                 alu_a_src_e,
  output logic                 alu_b_src_e,
  output logic                 pc_src_e,
  output logic                 pc_tgt_src_e,
  output logic                 mem_wr_en_m,
  output logic [2:0]           mem_size_m,
  output logic                 regfl_wr_en_m,
  output logic [RES_SRC_W-1:0] result_src_m,
  output logic                 regfl_wr_en_w,
  output logic [RES_SRC_W-1:0] result_src_w
);

  ctrl_word_t w_cw_d;
  imd_src_t   w_imd_d;
  ctrl_word_t r_e, r_m, r_w;
  logic       w_cond;

  cpu_ctrl_decoder u_dec (
    .opc     (opc),
    .funct3  (funct3),
    .funct7  (funct7),
    .cw      (w_cw_d),
    .imd_src (w_imd_d),
    .illegal (illegal_d)
  );

  always_ff @(posedge clk) begin
    if (rst || flush_e) r_e <= BUBBLE;
    else if (!stall_e)  r_e <= w_cw_d;
  end

  // A stalled E must not also issue into M, or it would run twice.
  always_ff @(posedge clk) begin
    if (rst || stall_e) r_m <= BUBBLE;
    else                r_m <= r_e;
  end

  always_ff @(posedge clk) begin
    if (rst) r_w <= BUBBLE;
    else     r_w <= r_m;
  end

  always_comb begin
    w_cond = 1'b0;
    case (r_e.funct3)
      3'b000:  w_cond = alu_zero_e;
      3'b001:  w_cond = !alu_zero_e;
      3'b100:  w_cond = alu_lt_e;
      3'b101:  w_cond = !alu_lt_e;
      3'b110:  w_cond = alu_ltu_e;
      3'b111:  w_cond = !alu_ltu_e;
      default: w_cond = 1'b0;
    endcase
  end

  assign imd_src_d     = IMD_SRC_W'(w_imd_d);
  assign alu_op_sel_e  = ALU_SEL_W'(r_e.alu_op_sel);
  assign alu_a_src_e   = r_e.alu_a_src;
  assign alu_b_src_e   = r_e.alu_b_src;
  assign pc_src_e      = r_e.jmp | (r_e.bra & w_cond);
  assign pc_tgt_src_e  = r_e.jalr;
  assign mem_wr_en_m   = r_m.mem_wr_en;
  assign mem_size_m    = r_m.funct3;
  assign regfl_wr_en_m = r_m.regfl_wr_en;
  assign result_src_m  = RES_SRC_W'(r_m.result_src);
  assign regfl_wr_en_w = r_w.regfl_wr_en;
  assign result_src_w  = RES_SRC_W'(r_w.result_src);

endmodule

// File: tb/tb_cpu_control_unit_v3.sv
// Directed bench for cpu_control_unit_v3.
// Hand-computed expectations, one check task, one summary line.
module tb_cpu_control_unit_v3;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opc;
  logic [2:0] funct3;
  logic       funct7;
  logic       stall_e, flush_e;
  logic       alu_zero_e, alu_lt_e, alu_ltu_e;
  logic [2:0] imd_src_d;
  logic       illegal_d;
  logic [3:0] alu_op_sel_e;
  logic       alu_a_src_e, alu_b_src_e;
  logic       pc_src_e, pc_tgt_src_e;
  logic       mem_wr_en_m;
  logic [2:0] mem_size_m;
  logic       regfl_wr_en_m;
  logic [1:0] result_src_m;
  logic       regfl_wr_en_w;
  logic [1:0] result_src_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_control_unit_v3 dut (
    .clk           (clk),
    .rst           (rst),
    .opc           (opc),
    .funct3        (funct3),
    .funct7        (funct7),
    .stall_e       (stall_e),
    .flush_e       (flush_e),
    .alu_zero_e    (alu_zero_e),
    .alu_lt_e      (alu_lt_e),
    .alu_ltu_e     (alu_ltu_e),
    .imd_src_d     (imd_src_d),
    .illegal_d     (illegal_d),
    .alu_op_sel_e  (alu_op_sel_e),
    .alu_a_src_e   (alu_a_src_e),
    .alu_b_src_e   (alu_b_src_e),
    .pc_src_e      (pc_src_e),
    .pc_tgt_src_e  (pc_tgt_src_e),
    .mem_wr_en_m   (mem_wr_en_m),
    .mem_size_m    (mem_size_m),
    .regfl_wr_en_m (regfl_wr_en_m),
    .result_src_m  (result_src_m),
    .regfl_wr_en_w (regfl_wr_en_w),
    .result_src_w  (result_src_w)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [6:0] o, input logic [2:0] f3,
                       input logic f7);
    opc    = o;
    funct3 = f3;
    funct7 = f7;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_e = 0; flush_e = 0;
    alu_zero_e = 0; alu_lt_e = 0; alu_ltu_e = 0;
    set_d(7'b0010011, 3'b000, 1'b0);
    step();
    step();
    chk("rst_alu_e", alu_op_sel_e, 0);
    chk("rst_pc_e", pc_src_e, 0);
    chk("rst_mwr_m", mem_wr_en_m, 0);
    chk("rst_rwr_m", regfl_wr_en_m, 0);
    chk("rst_rwr_w", regfl_wr_en_w, 0);
    rst = 1'b0;

    // SUB -> SRAI -> ADDI(f7=1)
    set_d(7'b0110011, 3'b000, 1'b1);
    chk("sub_imd_d", imd_src_d, 0);
    chk("sub_ill_d", illegal_d, 0);
    step();
    chk("sub_alu_e", alu_op_sel_e, 1);
    chk("sub_b_e", alu_b_src_e, 0);
    set_d(7'b0010011, 3'b101, 1'b1);
    step();
    chk("srai_alu_e", alu_op_sel_e, 9);
    chk("srai_b_e", alu_b_src_e, 1);
    chk("sub_rwr_m", regfl_wr_en_m, 1);
    set_d(7'b0010011, 3'b000, 1'b1);
    step();
    chk("addi_alu_e", alu_op_sel_e, 0);
    chk("sub_rwr_w", regfl_wr_en_w, 1);
    chk("sub_res_w", result_src_w, 0);

    // BLTU taken / not taken, then JALR, LUI
    set_d(7'b1100011, 3'b110, 1'b0);
    alu_ltu_e = 1;
    step();
    chk("bltu_pc_e", pc_src_e, 1);
    chk("bltu_tgt_e", pc_tgt_src_e, 0);
    chk("bltu_alu_e", alu_op_sel_e, 1);
    alu_ltu_e = 0;
    #1;
    chk("bltu_nt_pc_e", pc_src_e, 0);
    set_d(7'b1100111, 3'b000, 1'b0);
    chk("jalr_imd_d", imd_src_d, 0);
    step();
    chk("jalr_pc_e", pc_src_e, 1);
    chk("jalr_tgt_e", pc_tgt_src_e, 1);
    chk("bltu_mwr_m", mem_wr_en_m, 0);
    chk("bltu_rwr_m", regfl_wr_en_m, 0);
    set_d(7'b0110111, 3'b000, 1'b0);
    chk("lui_imd_d", imd_src_d, 4);
    step();
    chk("jalr_res_m", result_src_m, 2);
    chk("bltu_rwr_w", regfl_wr_en_w, 0);
    set_d(7'b0010011, 3'b000, 1'b0);
    step();
    chk("jalr_rwr_w", regfl_wr_en_w, 1);
    chk("jalr_res_w", result_src_w, 2);
    step();
    chk("lui_res_w", result_src_w, 3);

    // Branch conditions on other funct3 codes
    set_d(7'b1100011, 3'b000, 1'b0);
    alu_zero_e = 1;
    step();
    chk("beq_pc_e", pc_src_e, 1);
    alu_zero_e = 0;
    #1;
    chk("beq_nt_pc_e", pc_src_e, 0);
    set_d(7'b1100011, 3'b101, 1'b0);
    alu_lt_e = 1;
    step();
    chk("bge_nt_pc_e", pc_src_e, 0);
    set_d(7'b1100011, 3'b010, 1'b0);
    alu_zero_e = 1;
    step();
    chk("f3_010_pc_e", pc_src_e, 0);
    alu_zero_e = 0; alu_lt_e = 0;

    // SW stalled two cycles in E
    set_d(7'b0100011, 3'b010, 1'b0);
    step();
    chk("sw_b_e", alu_b_src_e, 1);
    set_d(7'b0010011, 3'b000, 1'b0);
    stall_e = 1;
    step();
    chk("stl1_mwr_m", mem_wr_en_m, 0);
    chk("stl1_b_e", alu_b_src_e, 1);
    step();
    chk("stl2_mwr_m", mem_wr_en_m, 0);
    stall_e = 0;
    step();
    chk("sw_mwr_m", mem_wr_en_m, 1);
    chk("sw_size_m", mem_size_m, 2);
    step();
    chk("sw_once_m", mem_wr_en_m, 0);

    // flush beats stall
    set_d(7'b1100111, 3'b000, 1'b0);
    step();
    chk("pre_fl_pc_e", pc_src_e, 1);
    stall_e = 1; flush_e = 1;
    step();
    chk("fl_pc_e", pc_src_e, 0);
    chk("fl_tgt_e", pc_tgt_src_e, 0);
    chk("fl_b_e", alu_b_src_e, 0);
    stall_e = 0; flush_e = 0;

    // Illegal opcode
    set_d(7'b1111111, 3'b010, 1'b1);
    chk("ill_d", illegal_d, 1);
    chk("ill_imd_d", imd_src_d, 0);
    step();
    chk("ill_b_e", alu_b_src_e, 0);
    chk("ill_pc_e", pc_src_e, 0);
    step();
    chk("ill_rwr_m", regfl_wr_en_m, 0);
    chk("ill_mwr_m", mem_wr_en_m, 0);
    step();
    chk("ill_rwr_w", regfl_wr_en_w, 0);

    // AUIPC
    set_d(7'b0010111, 3'b000, 1'b0);
    chk("auipc_imd_d", imd_src_d, 4);
    step();
    chk("auipc_a_e", alu_a_src_e, 1);

    // Mid-stream reset
    set_d(7'b0110011, 3'b000, 1'b0);
    step();
    set_d(7'b0110111, 3'b000, 1'b0);
    step();
    set_d(7'b1100111, 3'b000, 1'b0);
    step();
    chk("pre_rst_pc_e", pc_src_e, 1);
    chk("pre_rst_res_m", result_src_m, 3);
    chk("pre_rst_rwr_w", regfl_wr_en_w, 1);
    rst = 1;
    set_d(7'b0110111, 3'b000, 1'b0);
    step();
    chk("mrst_pc_e", pc_src_e, 0);
    chk("mrst_tgt_e", pc_tgt_src_e, 0);
    chk("mrst_b_e", alu_b_src_e, 0);
    chk("mrst_rwr_m", regfl_wr_en_m, 0);
    chk("mrst_res_m", result_src_m, 0);
    chk("mrst_rwr_w", regfl_wr_en_w, 0);
    chk("mrst_res_w", result_src_w, 0);
    chk("mrst_imd_d", imd_src_d, 4);
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
